// File: rtl/hazard_scoreboard_pkg.sv
// Shared tag layout and forwarding-select helpers for the hazard scoreboard.
// A tag is packed as {valid, dest, is_load}.
package hazard_scoreboard_pkg;

    localparam int TAG_VALID_W = 1;
    localparam int TAG_LOAD_W  = 1;

    // Select value meaning "take the operand from the register file".
    localparam int FWD_RF = 0;

    function automatic int tag_width(input int reg_w);
        return reg_w + TAG_VALID_W + TAG_LOAD_W;
    endfunction

    // The select must encode 0 (regfile) plus one code per tracked stage.
    function automatic int fw_width(input int depth);
        int w;
        w = $clog2(depth + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/hazard_tag_stage.sv
// One in-flight destination tag: async reset, hold, clear and load.
module hazard_tag_stage
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_W = 4,
    localparam int TW   = tag_width(REG_W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold,
    input  logic          clear,
    input  logic [TW-1:0] d,
    output logic [TW-1:0] q
);

    logic [TW-1:0] tag_reg;

    // Hold outranks clear so a flush raised during a freeze is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_reg <= '0;
        end else if (hold) begin
            tag_reg <= tag_reg;
        end else if (clear) begin
            tag_reg <= '0;
        end else begin
            tag_reg <= d;
        end
    end

    assign q = tag_reg;

endmodule

// File: rtl/hazard_scoreboard.sv
// Self-tracking hazard unit: shifts ID destination tags through PIPE_DEPTH stages
// and flags ID stalls. Define HAZARD_FWD_EN to add youngest-match forwarding selects.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_W      = 4,
    parameter int PIPE_DEPTH = 2,
    parameter int CNT_W      = 16,
    localparam int FW        = fw_width(PIPE_DEPTH),
    localparam int TW        = tag_width(REG_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic             id_valid,
    input  logic             id_wb_en,
    input  logic             id_mem_read,
    input  logic [REG_W-1:0] id_dest,
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic             two_src,
    input  logic             fwd_enable,
    output logic             hazard,
    output logic [FW-1:0]    fwd_sel1,
    output logic [FW-1:0]    fwd_sel2,
    output logic [CNT_W-1:0] stall_cycles
);

    logic [TW-1:0]         tag_d [PIPE_DEPTH];
    logic [TW-1:0]         tag_q [PIPE_DEPTH];
    logic [TW-1:0]         new_tag;
    logic [PIPE_DEPTH-1:0] hit1;
    logic [PIPE_DEPTH-1:0] hit2;
    logic [CNT_W-1:0]      stall_cycles_reg;

    // A stalled ID instruction must not enter EXE, so it becomes a bubble.
    assign new_tag = {id_valid & id_wb_en & ~hazard, id_dest, id_mem_read};

    generate
        for (genvar gi = 0; gi < PIPE_DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign tag_d[gi] = new_tag;
            end else begin : g_tail
                assign tag_d[gi] = tag_q[gi-1];
            end

            hazard_tag_stage #(
                .REG_W (REG_W)
            ) u_stage (
                .clk   (clk),
                .rst   (rst),
                .hold  (freeze),
                .clear (flush),
                .d     (tag_d[gi]),
                .q     (tag_q[gi])
            );

            assign hit1[gi] = tag_q[gi][TW-1] && (tag_q[gi][TW-2:1] == src1);
            assign hit2[gi] = tag_q[gi][TW-1] && (tag_q[gi][TW-2:1] == src2) && two_src;
        end
    endgenerate

`ifdef HAZARD_FWD_EN
    logic          found1;
    logic          found2;
    logic [FW-1:0] idx1;
    logic [FW-1:0] idx2;
    logic          load_use1;
    logic          load_use2;

    // Scan oldest to youngest so the lowest matching entry wins.
    always_comb begin
        found1 = 1'b0;
        found2 = 1'b0;
        idx1   = '0;
        idx2   = '0;
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            if (hit1[k]) begin
                found1 = 1'b1;
                idx1   = FW'(k);
            end
            if (hit2[k]) begin
                found2 = 1'b1;
                idx2   = FW'(k);
            end
        end
    end

    // Youngest match is entry 0 exactly when hit[0] is set.
    assign load_use1 = hit1[0] && tag_q[0][0];
    assign load_use2 = hit2[0] && tag_q[0][0];

    always_comb begin
        hazard   = 1'b0;
        fwd_sel1 = FW'(FWD_RF);
        fwd_sel2 = FW'(FWD_RF);
        if (id_valid) begin
            if (fwd_enable) begin
                hazard = load_use1 | load_use2;
                if (found1 && !load_use1) fwd_sel1 = idx1 + FW'(1);
                if (found2 && !load_use2) fwd_sel2 = idx2 + FW'(1);
            end else begin
                hazard = (|hit1) | (|hit2);
            end
        end
    end
`else
    logic unused_fwd_enable;
    assign unused_fwd_enable = fwd_enable;

    always_comb begin
        hazard   = id_valid & ((|hit1) | (|hit2));
        fwd_sel1 = FW'(FWD_RF);
        fwd_sel2 = FW'(FWD_RF);
    end
`endif

    // Counts real ID stall cycles only; frozen or flushed cycles are not stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_reg <= '0;
        end else if (hazard && !freeze && !flush && (stall_cycles_reg != '1)) begin
            stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cycles_reg;

endmodule
